// File: rtl/sap_ram_arbiter.sv
// sap_ram_arbiter: shares one synchronous-read RAM between the CPU and the loader.
// Ports: CLK/ARST_L/STRB control; cpu_*/ldr_* req/ack requesters; ram_* RAM side; owner, busy status.
module sap_ram_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_WAIT      = 4
) (
    input  logic              CLK,
    input  logic              ARST_L,
    input  logic              STRB,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              owner,
    output logic              busy
);

    localparam int SW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic              last_grant_q;
    logic              acc_we_q;
    logic              cpu_ack_q;
    logic              ldr_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              owner_q;
    logic              busy_q;
    logic              grant_ldr;

    // Winner selection, only meaningful while idle with a request pending.
    always_comb begin
        grant_ldr = ldr_req;
        if (cpu_req && ldr_req) begin
            if (PRIORITY_MODE == 0) begin
                // Alternate: loader wins only if the CPU had the last grant.
                grant_ldr = !last_grant_q;
            end else begin
                grant_ldr = (MAX_WAIT > 0) && (starve_q == MAXW);
            end
        end
    end

    // Starvation count of CPU wins over a waiting loader, saturating.
    always_comb begin
        starve_d = starve_q;
        if (!ldr_req || grant_ldr) begin
            starve_d = '0;
        end else if (starve_q != MAXW) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            state_q      <= S_IDLE;
            starve_q     <= '0;
            last_grant_q <= 1'b1;
            acc_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            ldr_ack_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            owner_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else if (STRB) begin
            unique case (state_q)
                S_IDLE: begin
                    starve_q <= starve_d;
                    if (cpu_req || ldr_req) begin
                        state_q      <= S_ACCESS;
                        owner_q      <= grant_ldr;
                        last_grant_q <= grant_ldr;
                        busy_q       <= 1'b1;
                        ram_en_q     <= 1'b1;
                        if (grant_ldr) begin
                            acc_we_q    <= ldr_we;
                            ram_we_q    <= ldr_we;
                            ram_addr_q  <= ldr_addr;
                            ram_wdata_q <= ldr_wdata;
                        end else begin
                            acc_we_q    <= cpu_we;
                            ram_we_q    <= cpu_we;
                            ram_addr_q  <= cpu_addr;
                            ram_wdata_q <= cpu_wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    ram_en_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    // RAM data is valid now, one strobed edge after the enable.
                    if (owner_q) begin
                        ldr_ack_q <= 1'b1;
                        if (!acc_we_q) ldr_rdata_q <= ram_rdata;
                    end else begin
                        cpu_ack_q <= 1'b1;
                        if (!acc_we_q) cpu_rdata_q <= ram_rdata;
                    end
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    cpu_ack_q <= 1'b0;
                    ldr_ack_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign ldr_ack   = ldr_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign owner     = owner_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sap_ram_arbiter.sv
// tb_sap_ram_arbiter: directed bench for sap_ram_arbiter with a scoreboard queue.
// Three instances: mode 0, mode 1 with MAX_WAIT=4, mode 1 with MAX_WAIT=0.
module tb_sap_ram_arbiter;

    logic       CLK = 1'b0;
    logic       ARST_L = 1'b0;
    logic       STRB = 1'b0;

    logic       cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic       a_cpu_ack, a_ldr_ack, a_ram_en, a_ram_we, a_owner, a_busy;
    logic [7:0] a_cpu_rdata, a_ldr_rdata, a_ram_addr, a_ram_wdata;
    logic [7:0] a_ram_rdata = 0;

    logic       b_req = 0;
    logic       b_cpu_ack, b_ldr_ack, b_ram_en, b_ram_we, b_owner, b_busy;
    logic [7:0] b_cpu_rdata, b_ldr_rdata, b_ram_addr, b_ram_wdata;
    logic       c_cpu_ack, c_ldr_ack, c_ram_en, c_ram_we, c_owner, c_busy;
    logic [7:0] c_cpu_rdata, c_ldr_rdata, c_ram_addr, c_ram_wdata;
    logic [7:0] zero8 = 8'h00;
    logic       zero1 = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] m_cpu = 0, m_ldr = 0;

    typedef struct {
        logic       who;
        logic       we;
        logic [7:0] rdata;
    } exp_t;
    exp_t sb[$];
    logic qa[$], qb[$], qc[$];

    always #5 CLK = ~CLK;

    sap_ram_arbiter #(.PRIORITY_MODE(0), .MAX_WAIT(4)) u_a (
        .CLK(CLK), .ARST_L(ARST_L), .STRB(STRB),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(a_ldr_ack), .ldr_rdata(a_ldr_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata),
        .owner(a_owner), .busy(a_busy)
    );

    sap_ram_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(4)) u_b (
        .CLK(CLK), .ARST_L(ARST_L), .STRB(STRB),
        .cpu_req(b_req), .cpu_we(zero1), .cpu_addr(zero8),
        .cpu_wdata(zero8), .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_req), .ldr_we(zero1), .ldr_addr(zero8),
        .ldr_wdata(zero8), .ldr_ack(b_ldr_ack), .ldr_rdata(b_ldr_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(zero8),
        .owner(b_owner), .busy(b_busy)
    );

    sap_ram_arbiter #(.PRIORITY_MODE(1), .MAX_WAIT(0)) u_c (
        .CLK(CLK), .ARST_L(ARST_L), .STRB(STRB),
        .cpu_req(b_req), .cpu_we(zero1), .cpu_addr(zero8),
        .cpu_wdata(zero8), .cpu_ack(c_cpu_ack), .cpu_rdata(c_cpu_rdata),
        .ldr_req(b_req), .ldr_we(zero1), .ldr_addr(zero8),
        .ldr_wdata(zero8), .ldr_ack(c_ldr_ack), .ldr_rdata(c_ldr_rdata),
        .ram_en(c_ram_en), .ram_we(c_ram_we), .ram_addr(c_ram_addr),
        .ram_wdata(c_ram_wdata), .ram_rdata(zero8),
        .owner(c_owner), .busy(c_busy)
    );

    // Synchronous-read RAM for instance A, advancing on strobed edges.
    always @(posedge CLK) begin
        if (STRB && a_ram_en) begin
            if (a_ram_we) mem[a_ram_addr] <= a_ram_wdata;
            else a_ram_rdata <= mem[a_ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe period: 4 CLKs, strobe on the last edge, sample 1 ns later.
    task automatic step();
        STRB = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        STRB = 1'b1;
        @(posedge CLK);
        #1;
        STRB = 1'b0;
    endtask

    function automatic logic [63:0] a_outs();
        return {26'd0, a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata,
                a_cpu_ack, a_ldr_ack, a_cpu_rdata, a_ldr_rdata,
                a_owner, a_busy};
    endfunction

    task automatic xact(input logic who, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        int n, en_c, we_c;
        logic got;
        e.who = who;
        e.we  = we;
        if (we) begin
            ref_mem[addr] = wdata;
            e.rdata = who ? m_ldr : m_cpu;
        end else begin
            e.rdata = ref_mem[addr];
            if (who) m_ldr = e.rdata;
            else m_cpu = e.rdata;
        end
        sb.push_back(e);
        if (who) begin
            ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        n = 0; en_c = 0; we_c = 0; got = 0;
        while (!got && n < 8) begin
            step();
            n++;
            en_c += int'(a_ram_en);
            we_c += int'(a_ram_we);
            if (a_cpu_ack || a_ldr_ack) got = 1;
        end
        chk("ack_seen", got, 1);
        e = sb.pop_front();
        if (got) begin
            chk("ack_latency", n, 3);
            chk("ack_who", {a_cpu_ack, a_ldr_ack}, e.who ? 2'b01 : 2'b10);
            chk("owner", a_owner, e.who);
            chk("win_rdata", e.who ? a_ldr_rdata : a_cpu_rdata, e.rdata);
            chk("other_rdata", e.who ? a_cpu_rdata : a_ldr_rdata,
                e.who ? m_cpu : m_ldr);
            chk("ram_en_periods", en_c, 1);
            chk("ram_we_periods", we_c, int'(e.we));
        end
        cpu_req = 0;
        ldr_req = 0;
        step();
        chk("ack_clear", {a_cpu_ack, a_ldr_ack}, 2'b00);
        chk("busy_clear", a_busy, 0);
    endtask

    initial begin
        int ga, gb, gc;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i ^ 8'h5A);
            ref_mem[i] = 8'(i ^ 8'h5A);
        end
        mem[8'h12] = 8'hA5;
        ref_mem[8'h12] = 8'hA5;

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outs", a_outs(), 64'd0);
        chk("reset_b", {b_ram_en, b_busy, b_owner, b_cpu_ack, b_ldr_ack}, 0);
        @(negedge CLK);
        ARST_L = 1'b1;

        // CPU read of 0x12
        xact(1'b0, 1'b0, 8'h12, 8'h00);

        // Loader write then CPU read of the same location
        xact(1'b1, 1'b1, 8'h80, 8'h3C);
        xact(1'b0, 1'b0, 8'h80, 8'h00);
        xact(1'b1, 1'b0, 8'h21, 8'h00);
        xact(1'b0, 1'b1, 8'h22, 8'hC3);
        xact(1'b1, 1'b0, 8'h22, 8'h00);

        // Strobe stall in WAIT
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h12;
        step();
        chk("stall_access_en", {a_ram_en, a_ram_addr}, {1'b1, 8'h12});
        step();
        cpu_req = 0;
        STRB = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("stall_frozen", {a_ram_en, a_ram_we, a_busy, a_cpu_ack, a_ram_addr},
            {1'b0, 1'b0, 1'b1, 1'b0, 8'h12});
        step();
        chk("stall_ack", {a_cpu_ack, a_cpu_rdata}, {1'b1, 8'hA5});
        m_cpu = 8'hA5;
        repeat (2) @(posedge CLK);
        #1;
        chk("ack_holds", a_cpu_ack, 1);
        step();
        chk("stall_ack_clr", {a_cpu_ack, a_busy}, 2'b00);

        // Reset during ACCESS of a CPU write
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 8'h77;
        step();
        chk("pre_rst_access", {a_ram_en, a_ram_we, a_busy}, 3'b111);
        @(negedge CLK);
        ARST_L = 1'b0;
        #1;
        chk("async_rst_outs", a_outs(), 64'd0);
        cpu_req = 0;
        @(negedge CLK);
        ARST_L = 1'b1;
        ga = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            ga += int'(a_cpu_ack | a_ldr_ack | a_busy);
        end
        chk("no_ack_after_rst", ga, 0);
        m_cpu = 0;
        m_ldr = 0;
        xact(1'b0, 1'b0, 8'h33, 8'h00);

        // Both requesters held high, from reset
        @(negedge CLK);
        ARST_L = 1'b0;
        @(negedge CLK);
        ARST_L = 1'b1;
        for (int i = 0; i < 10; i++) begin
            qa.push_back(1'((i % 2) == 1));
            qb.push_back(1'((i % 5) == 4));
            qc.push_back(1'b0);
        end
        cpu_req = 1; cpu_we = 0; ldr_req = 1; ldr_we = 0;
        b_req = 1;
        ga = 0; gb = 0; gc = 0;
        for (int s = 0; s < 40; s++) begin
            step();
            if (a_ram_en) begin
                ga++;
                if (qa.size() > 0) chk("rr_owner", a_owner, qa.pop_front());
            end
            if (b_ram_en) begin
                gb++;
                if (qb.size() > 0) chk("fp4_owner", b_owner, qb.pop_front());
            end
            if (c_ram_en) begin
                gc++;
                if (qc.size() > 0) chk("fp0_owner", c_owner, qc.pop_front());
            end
        end
        chk("rr_grants", ga, 10);
        chk("fp4_grants", gb, 10);
        chk("fp0_grants", gc, 10);
        cpu_req = 0; ldr_req = 0; b_req = 0;
        repeat (4) step();
        chk("final_idle", {a_busy, b_busy, c_busy}, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
